// File: rtl/aont_pkg.sv
// Shared types, constants and MAC helper for the AONT chaffing path.
// The winnower uses the same mac_fold so both ends agree on the tag.
package aont_pkg;

    localparam int BW     = 64;
    localparam int MACLEN = 8;

    typedef logic [BW-1:0]     block_t;
    typedef logic [MACLEN-1:0] mac_t;

    // Fibonacci taps 64,63,61,60 expressed as bit positions 63,62,60,59
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        SECOND
    } state_t;

    // XOR of every MACLEN-wide slice of the block, the key and the sequence
    // number (caller zero-extends the sequence number into seq)
    function automatic mac_t mac_fold(input block_t block, input mac_t key, input mac_t seq);
        mac_t acc;
        acc = key ^ seq;
        for (int i = 0; i < BW / MACLEN; i++) begin
            acc = acc ^ block[i*MACLEN +: MACLEN];
        end
        return acc;
    endfunction

endpackage

// File: rtl/chaff_lfsr.sv
// 64-bit Fibonacci LFSR shifting left with feedback into bit 0.
// Advances only when i_step is high; reloads SEED on reset.
module chaff_lfsr
    import aont_pkg::*;
#(
    parameter logic [63:0] SEED = 64'hACE1_0F0F_5A5A_1234
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_step,
    output logic [63:0] o_state
);

    logic [63:0] r_lfsr;
    logic        w_fb;

    assign w_fb    = ^(r_lfsr & LFSR_TAPS);
    assign o_state = r_lfsr;

    // Shift register: one step per enabled clock, SEED on reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lfsr <= SEED;
        end else if (i_step) begin
            r_lfsr <= {r_lfsr[62:0], w_fb};
        end
    end

endmodule

// File: rtl/aont_chaffer.sv
// Splits one AONT message into blocks and emits each as a (real, chaff)
// pair. The pair order and chaff content come from the LFSR value held
// while the pair is being sent; the LFSR steps once per completed pair.
module aont_chaffer
    import aont_pkg::*;
#(
    parameter int          noofblocks = 8,
    parameter int          lslen      = 16,
    parameter int          lslenlog   = 4,
    parameter int          maclen     = 8,
    parameter logic [63:0] SEED       = 64'hACE1_0F0F_5A5A_1234
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [lslen*lslenlog*noofblocks-1:0]  msgIn,
    input  logic [maclen-1:0]                     mac_key,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [lslen*lslenlog-1:0]             out_block,
    output logic [$clog2(noofblocks)-1:0]         out_seq,
    output logic [maclen-1:0]                     out_mac,
    output logic                                  out_is_chaff
);

    // Block and MAC widths here must equal the package BW / MACLEN
    localparam int BLK_W = lslen * lslenlog;
    localparam int SW    = $clog2(noofblocks);

    state_t        r_state;
    state_t        w_state_next;
    logic          r_alive;
    logic [SW-1:0] r_idx;
    logic [SW-1:0] w_idx_inc;
    mac_t          r_key;
    block_t        r_cur_block;
    block_t        r_blocks [noofblocks];
    block_t        w_in_blocks [noofblocks];
    logic [63:0]   w_lfsr;
    logic          w_accept;
    logic          w_step;
    logic          w_last;
    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_is_chaff;
    mac_t          w_real_mac;
    mac_t          w_chaff_mac;

    for (genvar gi = 0; gi < noofblocks; gi++) begin : g_split
        assign w_in_blocks[gi] = msgIn[gi*BLK_W +: BLK_W];
    end

    assign w_idx_inc = r_idx + SW'(1);
    assign w_last    = (r_idx == SW'(noofblocks - 1));

    chaff_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rstn    (rstn),
        .i_step  (w_step),
        .o_state (w_lfsr)
    );

    // Next-state and handshake decode; a pair completes on the SECOND beat
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = r_alive;
                if (in_valid && r_alive) begin
                    w_accept     = 1'b1;
                    w_state_next = FIRST;
                end
            end
            FIRST: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = SECOND;
                end
            end
            SECOND: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_step       = 1'b1;
                    w_state_next = w_last ? IDLE : FIRST;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Control state, latched key and the prefetched real block of the current pair
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_alive     <= 1'b0;
            r_idx       <= '0;
            r_key       <= '0;
            r_cur_block <= '0;
        end else begin
            r_state <= w_state_next;
            r_alive <= 1'b1;
            if (w_accept) begin
                r_idx       <= '0;
                r_key       <= mac_key;
                r_cur_block <= w_in_blocks[0];
            end else if (w_step && !w_last) begin
                r_idx       <= w_idx_inc;
                r_cur_block <= r_blocks[w_idx_inc];
            end
        end
    end

    // Message store; contents are don't-care until the next accept
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < noofblocks; i++) begin
                r_blocks[i] <= w_in_blocks[i];
            end
        end
    end

    // L[0]=0 sends real first; the chaff tag is offset by a nonzero mask
    always_comb begin
        w_is_chaff  = (r_state == FIRST) ? w_lfsr[0] : ~w_lfsr[0];
        w_real_mac  = mac_fold(r_cur_block, r_key, mac_t'(r_idx));
        w_chaff_mac = mac_fold(w_lfsr, r_key, mac_t'(r_idx)) ^ mac_t'(w_lfsr[15:8] | 8'h01);
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = w_out_valid;
    assign out_is_chaff = w_out_valid & w_is_chaff;
    assign out_seq      = w_out_valid ? r_idx : '0;
    assign out_block    = !w_out_valid ? '0 : (w_is_chaff ? w_lfsr : r_cur_block);
    assign out_mac      = !w_out_valid ? '0 : (w_is_chaff ? w_chaff_mac : w_real_mac);

endmodule

// File: tb/tb_aont_chaffer.sv
// Directed bench for aont_chaffer: zero message, known block, backpressure,
// input hold, mid-message reset and a randomised winnowing sweep.
module tb_aont_chaffer;

    localparam int NB     = 8;
    localparam int BW     = 64;
    localparam int NBEATS = 2 * NB;
    localparam logic [63:0] SEED = 64'hACE1_0F0F_5A5A_1234;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [NB*BW-1:0] msgIn = '0;
    logic [7:0]      mac_key = 8'h00;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [63:0]     out_block;
    logic [2:0]      out_seq;
    logic [7:0]      out_mac;
    logic            out_is_chaff;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] m_lfsr = SEED;
    logic [63:0] exp_lfsr_after;
    logic [63:0] exp_block [NBEATS];
    logic [7:0]  exp_mac   [NBEATS];
    logic [2:0]  exp_seq   [NBEATS];
    logic        exp_chaff [NBEATS];
    logic [63:0] fp_block  [2];
    logic [7:0]  fp_mac    [2];
    logic        fp_chaff  [2];
    logic [63:0] pu_block  [2];
    logic [7:0]  pu_mac    [2];
    logic        pu_chaff  [2];
    logic        seen_order0 = 1'b0;
    logic        seen_order1 = 1'b0;

    always #5 clk = ~clk;

    aont_chaffer dut (
        .clk          (clk),
        .rstn         (rstn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .msgIn        (msgIn),
        .mac_key      (mac_key),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_block    (out_block),
        .out_seq      (out_seq),
        .out_mac      (out_mac),
        .out_is_chaff (out_is_chaff)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] tb_step(input logic [63:0] l);
        return {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
    endfunction

    function automatic logic [7:0] tb_fold(input logic [63:0] b, input logic [7:0] k, input logic [2:0] s);
        logic [7:0] f;
        f = k ^ {5'd0, s};
        for (int i = 0; i < 8; i++) f = f ^ b[i*8 +: 8];
        return f;
    endfunction

    task automatic build_exp(input logic [NB*BW-1:0] msg, input logic [7:0] key);
        logic [63:0] l;
        logic [63:0] blk;
        logic [7:0]  rmac;
        logic [7:0]  cmac;
        l = m_lfsr;
        for (int p = 0; p < NB; p++) begin
            blk  = msg[p*BW +: BW];
            rmac = tb_fold(blk, key, 3'(p));
            cmac = tb_fold(l, key, 3'(p)) ^ (l[15:8] | 8'h01);
            exp_seq[2*p]     = 3'(p);
            exp_seq[2*p+1]   = 3'(p);
            exp_chaff[2*p]   = l[0];
            exp_chaff[2*p+1] = ~l[0];
            exp_block[2*p]   = l[0] ? l : blk;
            exp_mac[2*p]     = l[0] ? cmac : rmac;
            exp_block[2*p+1] = l[0] ? blk : l;
            exp_mac[2*p+1]   = l[0] ? rmac : cmac;
            l = tb_step(l);
        end
        exp_lfsr_after = l;
    endtask

    // mode 0: out_ready always 1; mode 1: 1,0,0,1 pattern. abort_at>0 stops after that many beats.
    task automatic run_msg(input string name, input logic [NB*BW-1:0] msg, input logic [7:0] key,
                           input int mode, input int abort_at, input bit hold);
        int          k;
        int          cyc;
        int          wc;
        logic        rdy;
        logic [63:0] rec   [NB];
        int          nreal [NB];
        for (int s = 0; s < NB; s++) begin
            rec[s]   = '0;
            nreal[s] = 0;
        end
        build_exp(msg, key);
        wc = 0;
        while (in_ready !== 1'b1 && wc < 50) begin
            @(negedge clk);
            wc++;
        end
        check({name, "_in_ready_idle"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        msgIn    = msg;
        mac_key  = key;
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
        msgIn   = {16{$urandom}};
        mac_key = ~key;
        k   = 0;
        cyc = 0;
        while (k < NBEATS && cyc < 200) begin
            rdy = (mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
            out_ready = rdy;
            check({name, "_out_valid"}, 64'(out_valid), 64'd1);
            check({name, "_in_ready_busy"}, 64'(in_ready), 64'd0);
            check({name, "_block"}, out_block, exp_block[k]);
            check({name, "_seq"}, 64'(out_seq), 64'(exp_seq[k]));
            check({name, "_mac"}, 64'(out_mac), 64'(exp_mac[k]));
            check({name, "_chaff"}, 64'(out_is_chaff), 64'(exp_chaff[k]));
            if (out_valid && rdy) begin
                if (tb_fold(out_block, key, out_seq) == out_mac) begin
                    rec[out_seq]   = out_block;
                    nreal[out_seq] = nreal[out_seq] + 1;
                end
                if (k < 2) begin
                    fp_block[k] = out_block;
                    fp_mac[k]   = out_mac;
                    fp_chaff[k] = out_is_chaff;
                end
                if ((k % 2) == 0) begin
                    if (out_is_chaff) seen_order1 = 1'b1;
                    else              seen_order0 = 1'b1;
                end
                k++;
            end
            if (hold) msgIn = {16{$urandom}};
            @(negedge clk);
            cyc++;
            if (abort_at != 0 && k == abort_at) break;
        end
        if (abort_at == 0) begin
            check({name, "_beats"}, 64'(k), 64'(NBEATS));
            if (mode == 0) check({name, "_no_bubble"}, 64'(cyc), 64'(NBEATS));
            check({name, "_in_ready_after"}, 64'(in_ready), 64'd1);
            check({name, "_out_valid_after"}, 64'(out_valid), 64'd0);
            in_valid  = 1'b0;
            out_ready = 1'b0;
            for (int s = 0; s < NB; s++) begin
                check({name, "_winnow_block"}, rec[s], msg[s*BW +: BW]);
                check({name, "_winnow_count"}, 64'(nreal[s]), 64'd1);
            end
            m_lfsr = exp_lfsr_after;
            $display("msg %s: %0d beats in %0d cycles", name, k, cyc);
        end else begin
            $display("msg %s: aborted after %0d beats", name, k);
        end
    endtask

    initial begin
        logic [NB*BW-1:0] msg;
        int ri;
        int ci;

        // Reset state
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_block", out_block, 64'd0);
        check("rst_out_seq", 64'(out_seq), 64'd0);
        check("rst_out_mac", 64'(out_mac), 64'd0);
        check("rst_out_is_chaff", 64'(out_is_chaff), 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rel_in_ready_low", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("rel_in_ready_high", 64'(in_ready), 64'd1);

        // Zero message, key A5; first pair from SEED: order 0, chaff = SEED, tag DD
        run_msg("zero", '0, 8'hA5, 0, 0, 1'b0);
        check("zero_fp_real_block", fp_block[0], 64'd0);
        check("zero_fp_real_mac", 64'(fp_mac[0]), 64'hA5);
        check("zero_fp_order", 64'(fp_chaff[0]), 64'd0);
        check("zero_fp_chaff_block", fp_block[1], SEED);
        check("zero_fp_chaff_mac", 64'(fp_mac[1]), 64'hDD);
        for (int i = 0; i < 2; i++) begin
            pu_block[i] = fp_block[i];
            pu_mac[i]   = fp_mac[i];
            pu_chaff[i] = fp_chaff[i];
        end

        // Known block 0, key 0
        msg = '0;
        for (int i = 0; i < NB; i++) msg[i*BW +: BW] = 64'h1111_0000_0000_0000 * 64'(i + 1);
        msg[63:0] = 64'h0102030405060708;
        run_msg("known", msg, 8'h00, 0, 0, 1'b0);
        ri = fp_chaff[0] ? 1 : 0;
        ci = 1 - ri;
        check("known_real_mac", 64'(fp_mac[ri]), 64'h08);
        check("known_chaff_tag_wrong", 64'(fp_mac[ci] != tb_fold(fp_block[ci], 8'h00, 3'd0)), 64'd1);

        // Backpressure
        for (int i = 0; i < 2 * NB; i++) msg[i*32 +: 32] = $urandom;
        run_msg("stall", msg, 8'h3C, 1, 0, 1'b0);

        // in_valid held, msgIn changing during emission
        for (int i = 0; i < 2 * NB; i++) msg[i*32 +: 32] = $urandom;
        run_msg("hold", msg, 8'h5E, 0, 0, 1'b1);

        // Reset mid-message after beat 5
        run_msg("abort", msg, 8'h77, 0, 5, 1'b0);
        rstn = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out_block", out_block, 64'd0);
        check("abort_out_seq", 64'(out_seq), 64'd0);
        check("abort_out_mac", 64'(out_mac), 64'd0);
        check("abort_out_is_chaff", 64'(out_is_chaff), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rstn   = 1'b1;
        m_lfsr = SEED;
        @(negedge clk);
        run_msg("post_rst", '0, 8'hA5, 0, 0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            check("post_rst_fp_block", fp_block[i], pu_block[i]);
            check("post_rst_fp_mac", 64'(fp_mac[i]), 64'(pu_mac[i]));
            check("post_rst_fp_chaff", 64'(fp_chaff[i]), 64'(pu_chaff[i]));
        end

        // Random sweep with winnowing
        for (int n = 0; n < 100; n++) begin
            for (int i = 0; i < 2 * NB; i++) msg[i*32 +: 32] = $urandom;
            run_msg($sformatf("rand%0d", n), msg, 8'($urandom), n % 2, 0, 1'b0);
        end
        check("order0_seen", 64'(seen_order0), 64'd1);
        check("order1_seen", 64'(seen_order1), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
